// File: rtl/clock_pkg.sv
// Shared types and constants for the clock mode/time-set sequencer.
package clock_pkg;

  typedef enum logic [2:0] {
    RUN,
    SET_HOUR,
    SET_MIN,
    SET_SEC,
    COMMIT
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  localparam int HOUR_W     = 5;
  localparam int MINSEC_W   = 6;
  localparam int HOURS_MAX  = 23;
  localparam int MINSEC_MAX = 59;

  // Increment with wrap back to zero once max_value has been reached.
  function automatic int wrap_inc(input int value, input int max_value);
    return (value >= max_value) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/clock_set_controller_button_event.sv
// Rising-edge event generator for a debounced button, with optional
// hold-to-repeat (REPEAT_EN) producing further single-cycle events.
module button_event #(
  parameter bit REPEAT_EN     = 1'b0,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic clear,
  output logic evt
);

  logic btn_reg;
  logic edge_evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_reg <= 1'b0;
    end else begin
      btn_reg <= btn;
    end
  end

  assign edge_evt = btn & ~btn_reg;

  generate
    if (REPEAT_EN) begin : g_repeat
      localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int CNT_W   = $clog2(CNT_MAX + 1);
      localparam logic [CNT_W-1:0] DELAY_V  = CNT_W'(REPEAT_DELAY);
      localparam logic [CNT_W-1:0] PERIOD_V = CNT_W'(REPEAT_PERIOD);

      logic [CNT_W-1:0] hold_cnt_reg;
      logic             repeating_reg;
      logic             fire;

      // hold_cnt_reg equals the number of cycles since the press edge,
      // restarting at 1 after each synthetic event.
      assign fire = btn && (repeating_reg ? (hold_cnt_reg == PERIOD_V)
                                          : (hold_cnt_reg == DELAY_V));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          hold_cnt_reg  <= '0;
          repeating_reg <= 1'b0;
        end else if (!btn || clear) begin
          hold_cnt_reg  <= '0;
          repeating_reg <= 1'b0;
        end else if (fire) begin
          hold_cnt_reg  <= CNT_W'(1);
          repeating_reg <= 1'b1;
        end else begin
          hold_cnt_reg  <= hold_cnt_reg + 1'b1;
        end
      end

      assign evt = edge_evt | fire;
    end else begin : g_edge_only
      logic unused_clear;
      assign unused_clear = clear;
      assign evt = edge_evt;
    end
  endgenerate

endmodule

// File: rtl/clock_set_controller.sv
// Mode/time-set sequencer for the hour/minute/second counter chain.
// Optional hold-to-repeat on btn_inc: define CLOCK_SET_AUTO_REPEAT_EN.
module clock_set_controller
  import clock_pkg::*;
#(
  parameter int TIMEOUT_S     = 10,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick_1hz,
  input  logic                btn_mode,
  input  logic                btn_inc,
  input  logic [HOUR_W-1:0]   cur_hours,
  input  logic [MINSEC_W-1:0] cur_minutes,
  input  logic [MINSEC_W-1:0] cur_seconds,
  output logic                count_en,
  output logic                load,
  output logic [HOUR_W-1:0]   load_hours,
  output logic [MINSEC_W-1:0] load_minutes,
  output logic [MINSEC_W-1:0] load_seconds,
  output logic [1:0]          edit_field,
  output logic                blink
);

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  localparam bit INC_REPEAT = 1'b1;
`else
  localparam bit INC_REPEAT = 1'b0;
`endif

  localparam int TO_W = $clog2(TIMEOUT_S + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_S - 1);

  state_t                state_reg;
  logic [HOUR_W-1:0]     edit_hours_reg;
  logic [MINSEC_W-1:0]   edit_minutes_reg;
  logic [MINSEC_W-1:0]   edit_seconds_reg;
  logic [TO_W-1:0]       timeout_reg;
  logic                  count_en_reg;
  logic                  load_reg;
  logic [HOUR_W-1:0]     load_hours_reg;
  logic [MINSEC_W-1:0]   load_minutes_reg;
  logic [MINSEC_W-1:0]   load_seconds_reg;
  logic [1:0]            edit_field_reg;
  logic                  blink_reg;

  logic mode_evt;
  logic inc_evt;
  logic in_set;
  logic timeout_hit;
  logic state_change;

  button_event #(
    .REPEAT_EN    (1'b0),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_mode_event (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_mode),
    .clear(1'b0),
    .evt  (mode_evt)
  );

  button_event #(
    .REPEAT_EN    (INC_REPEAT),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_inc_event (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_inc),
    .clear(state_change),
    .evt  (inc_evt)
  );

  assign in_set = (state_reg == SET_HOUR) || (state_reg == SET_MIN) || (state_reg == SET_SEC);

  // Any button event in the same cycle restarts the idle count instead.
  assign timeout_hit = in_set && tick_1hz && !mode_evt && !inc_evt && (timeout_reg == TO_LAST);

  assign state_change = ((state_reg == RUN) && mode_evt)
                     || (in_set && (mode_evt || timeout_hit))
                     || (state_reg == COMMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= RUN;
      edit_hours_reg   <= '0;
      edit_minutes_reg <= '0;
      edit_seconds_reg <= '0;
      timeout_reg      <= '0;
      count_en_reg     <= 1'b1;
      load_reg         <= 1'b0;
      load_hours_reg   <= '0;
      load_minutes_reg <= '0;
      load_seconds_reg <= '0;
      edit_field_reg   <= FIELD_NONE;
      blink_reg        <= 1'b1;
    end else begin
      load_reg <= 1'b0;
      case (state_reg)
        RUN: begin
          count_en_reg   <= 1'b1;
          edit_field_reg <= FIELD_NONE;
          blink_reg      <= 1'b1;
          if (mode_evt) begin
            state_reg        <= SET_HOUR;
            edit_hours_reg   <= cur_hours;
            edit_minutes_reg <= cur_minutes;
            edit_seconds_reg <= cur_seconds;
            timeout_reg      <= '0;
            count_en_reg     <= 1'b0;
            edit_field_reg   <= FIELD_HOUR;
          end
        end

        SET_HOUR, SET_MIN, SET_SEC: begin
          if (mode_evt) begin
            timeout_reg <= '0;
            if (tick_1hz) blink_reg <= ~blink_reg;
            case (state_reg)
              SET_HOUR: begin
                state_reg      <= SET_MIN;
                edit_field_reg <= FIELD_MIN;
              end
              SET_MIN: begin
                state_reg      <= SET_SEC;
                edit_field_reg <= FIELD_SEC;
              end
              default: begin
                state_reg        <= COMMIT;
                edit_field_reg   <= FIELD_NONE;
                blink_reg        <= 1'b1;
                load_reg         <= 1'b1;
                load_hours_reg   <= edit_hours_reg;
                load_minutes_reg <= edit_minutes_reg;
                load_seconds_reg <= edit_seconds_reg;
              end
            endcase
          end else if (timeout_hit) begin
            state_reg      <= RUN;
            timeout_reg    <= '0;
            count_en_reg   <= 1'b1;
            edit_field_reg <= FIELD_NONE;
            blink_reg      <= 1'b1;
          end else if (inc_evt) begin
            timeout_reg <= '0;
            blink_reg   <= 1'b1;
            case (state_reg)
              SET_HOUR: edit_hours_reg   <= HOUR_W'(wrap_inc(int'(edit_hours_reg), HOURS_MAX));
              SET_MIN:  edit_minutes_reg <= MINSEC_W'(wrap_inc(int'(edit_minutes_reg), MINSEC_MAX));
              default:  edit_seconds_reg <= MINSEC_W'(wrap_inc(int'(edit_seconds_reg), MINSEC_MAX));
            endcase
          end else if (tick_1hz) begin
            timeout_reg <= timeout_reg + 1'b1;
            blink_reg   <= ~blink_reg;
          end
        end

        COMMIT: begin
          state_reg      <= RUN;
          count_en_reg   <= 1'b1;
          edit_field_reg <= FIELD_NONE;
          blink_reg      <= 1'b1;
        end

        default: begin
          state_reg      <= RUN;
          count_en_reg   <= 1'b1;
          edit_field_reg <= FIELD_NONE;
          blink_reg      <= 1'b1;
        end
      endcase
    end
  end

  assign count_en     = count_en_reg;
  assign load         = load_reg;
  assign load_hours   = load_hours_reg;
  assign load_minutes = load_minutes_reg;
  assign load_seconds = load_seconds_reg;
  assign edit_field   = edit_field_reg;
  assign blink        = blink_reg;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed self-checking bench for clock_set_controller; the auto-repeat
// section runs only when CLOCK_SET_AUTO_REPEAT_EN is defined.
module tb_clock_set_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] cur_hours = 5'd0;
  logic [5:0] cur_minutes = 6'd0;
  logic [5:0] cur_seconds = 6'd0;
  logic       count_en;
  logic       load;
  logic [4:0] load_hours;
  logic [5:0] load_minutes;
  logic [5:0] load_seconds;
  logic [1:0] edit_field;
  logic       blink;

  int errors = 0;
  int checks = 0;
  int load_count = 0;
  int seen_h = 0;
  int seen_m = 0;
  int seen_s = 0;

  clock_set_controller #(
    .TIMEOUT_S    (10),
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick_1hz    (tick_1hz),
    .btn_mode    (btn_mode),
    .btn_inc     (btn_inc),
    .cur_hours   (cur_hours),
    .cur_minutes (cur_minutes),
    .cur_seconds (cur_seconds),
    .count_en    (count_en),
    .load        (load),
    .load_hours  (load_hours),
    .load_minutes(load_minutes),
    .load_seconds(load_seconds),
    .edit_field  (edit_field),
    .blink       (blink)
  );

  always #5 clk = ~clk;

  // Count every cycle in which load is high and latch what it carried.
  always @(posedge clk) begin
    if (load === 1'b1) begin
      load_count <= load_count + 1;
      seen_h <= int'(load_hours);
      seen_m <= int'(load_minutes);
      seen_s <= int'(load_seconds);
    end
  end

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    cyc(1);
    btn_mode = 1'b0;
    cyc(1);
  endtask

  task automatic press_inc();
    btn_inc = 1'b1;
    cyc(1);
    btn_inc = 1'b0;
    cyc(1);
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    cyc(1);
    tick_1hz = 1'b0;
    cyc(1);
  endtask

  task automatic edit_seq(input int hi, input int mi, input int si);
    press_mode();
    repeat (hi) press_inc();
    press_mode();
    repeat (mi) press_inc();
    press_mode();
    repeat (si) press_inc();
    press_mode();
    cyc(1);
  endtask

  int exp_h [3] = '{23, 0, 1};
  int n_loads;

  initial begin
    cyc(3);
    check("reset_count_en", count_en, 1);
    check("reset_load", load, 0);
    check("reset_edit_field", edit_field, 0);
    check("reset_blink", blink, 1);
    check("reset_load_hours", load_hours, 0);
    reset = 1'b0;
    cyc(2);

    // Idle ticks in RUN must not disturb the outputs.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("run_count_en", count_en, 1);
      check("run_load", load, 0);
      check("run_edit_field", edit_field, 0);
      check("run_blink", blink, 1);
    end

    // Full edit 12:34:56 -> 14:35:56.
    cur_hours = 5'd12; cur_minutes = 6'd34; cur_seconds = 6'd56;
    press_mode();
    check("set_hour_field", edit_field, 1);
    check("set_hour_count_en", count_en, 0);
    press_inc();
    press_inc();
    press_mode();
    check("set_min_field", edit_field, 2);
    press_inc();
    press_mode();
    check("set_sec_field", edit_field, 3);
    check("set_sec_count_en", count_en, 0);
    btn_mode = 1'b1;
    cyc(1);
    check("commit_load", load, 1);
    check("commit_hours", load_hours, 14);
    check("commit_minutes", load_minutes, 35);
    check("commit_seconds", load_seconds, 56);
    check("commit_count_en", count_en, 0);
    btn_mode = 1'b0;
    cyc(1);
    check("post_commit_load", load, 0);
    check("post_commit_count_en", count_en, 1);
    check("load_cycles", load_count, 1);
    $display("txn edit 12:34:56 -> %0d:%0d:%0d", seen_h, seen_m, seen_s);

    // Hours wrap from 22 and minutes wrap from 59; inc in RUN is ignored.
    cur_hours = 5'd22; cur_minutes = 6'd59; cur_seconds = 6'd0;
    press_inc();
    for (int n = 1; n <= 3; n++) begin
      n_loads = load_count;
      edit_seq(n, 1, 0);
      check("wrap_load_count", load_count, n_loads + 1);
      check("wrap_hours", seen_h, exp_h[n-1]);
      check("wrap_minutes", seen_m, 0);
      check("wrap_seconds", seen_s, 0);
      $display("txn wrap inc=%0d -> %0d:%0d:%0d", n, seen_h, seen_m, seen_s);
    end

    // Timeout from SET_MIN after 10 idle ticks, no load.
    n_loads = load_count;
    press_mode();
    press_mode();
    check("to_blink_entry", blink, 1);
    tick();
    check("to_blink_toggle", blink, 0);
    for (int i = 2; i <= 9; i++) tick();
    check("to_still_set", edit_field, 2);
    check("to_still_frozen", count_en, 0);
    tick();
    check("to_exit_field", edit_field, 0);
    check("to_exit_count_en", count_en, 1);
    check("to_exit_blink", blink, 1);
    check("to_no_load", load_count, n_loads);
    $display("txn timeout exit field=%0d", edit_field);

    // Simultaneous mode and inc in SET_HOUR: mode wins.
    cur_hours = 5'd12; cur_minutes = 6'd34; cur_seconds = 6'd56;
    press_mode();
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    cyc(1);
    check("both_field", edit_field, 2);
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    cyc(1);
    n_loads = load_count;
    press_mode();
    press_mode();
    cyc(1);
    check("both_load_count", load_count, n_loads + 1);
    check("both_hours", seen_h, 12);
    check("both_minutes", seen_m, 34);
    $display("txn same-cycle -> %0d:%0d:%0d", seen_h, seen_m, seen_s);

    // Asynchronous reset during SET_SEC discards the edit.
    n_loads = load_count;
    press_mode();
    press_mode();
    press_mode();
    press_inc();
    reset = 1'b1;
    #1;
    check("rst_field", edit_field, 0);
    check("rst_count_en", count_en, 1);
    check("rst_load", load, 0);
    check("rst_load_hours", load_hours, 0);
    cyc(2);
    reset = 1'b0;
    cyc(3);
    check("rst_no_load", load_count, n_loads);
    check("rst_run_field", edit_field, 0);
    $display("txn reset mid-edit field=%0d", edit_field);

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    begin
      int hold_tab [4] = '{20, 8, 9, 13};
      int sec_tab  [4] = '{4, 1, 2, 3};
      cur_hours = 5'd5; cur_minutes = 6'd6; cur_seconds = 6'd0;
      for (int t = 0; t < 4; t++) begin
        n_loads = load_count;
        press_mode();
        press_mode();
        press_mode();
        btn_inc = 1'b1;
        cyc(hold_tab[t]);
        btn_inc = 1'b0;
        cyc(1);
        press_mode();
        cyc(1);
        check("rep_load_count", load_count, n_loads + 1);
        check("rep_seconds", seen_s, sec_tab[t]);
        $display("txn repeat hold=%0d -> sec %0d", hold_tab[t], seen_s);
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
